// File: rtl/command_serializer.sv
// command_serializer: streams a latched controller command out as bytes (MSB first per field),
// with one idle gap cycle after every consumed byte. Define SERIALIZER_TIMEOUT_EN for the ack-timeout abort.
module command_serializer #(
    parameter int data_width     = 16,
    parameter int instr_width    = 32,
    parameter int timeout_cycles = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [7:0]              cmd_opcode,
    input  logic [7:0]              cmd_block,
    input  logic [7:0]              cmd_reg,
    input  logic [data_width-1:0]   cmd_data,
    input  logic [instr_width-1:0]  cmd_instr,
    input  logic [2*data_width-1:0] cmd_delay,
    output logic [7:0]              out_byte,
    output logic                    out_valid,
    input  logic                    out_next,
    output logic                    busy,
    output logic                    done,
    output logic                    invalid,
    output logic                    timeout
);

    // Controller command codes; bit 3 selects the target pipeline for per-pipeline commands.
    localparam logic [7:0] PIPE_SEL                   = 8'h08;
    localparam logic [7:0] CMD_WRITE_BLOCK_INSTR      = 8'h01;
    localparam logic [7:0] CMD_WRITE_BLOCK_REG        = 8'h02;
    localparam logic [7:0] CMD_UPDATE_BLOCK_REG       = 8'h03;
    localparam logic [7:0] CMD_ALLOC_DELAY            = 8'h04;
    localparam logic [7:0] CMD_SET_INPUT_GAIN         = 8'h05;
    localparam logic [7:0] CMD_SET_OUTPUT_GAIN        = 8'h06;
    localparam logic [7:0] CMD_RESET_PIPELINE         = 8'h07;
    localparam logic [7:0] CMD_COMMIT_REG_UPDATES     = 8'h10;
    localparam logic [7:0] CMD_SWAP_PIPELINES         = 8'h11;

    localparam int DATA_BYTES  = data_width / 8;
    localparam int INSTR_BYTES = instr_width / 8;
    localparam int DELAY_BYTES = 2 * DATA_BYTES;
    localparam int MAX_BYTES   = (INSTR_BYTES > DELAY_BYTES) ? INSTR_BYTES : DELAY_BYTES;
    localparam int CNT_W       = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

    if ((data_width % 8) != 0 || (instr_width % 8) != 0 || data_width < 8 ||
        instr_width < 8 || timeout_cycles < 1) begin : g_param_check
        $error("command_serializer: widths must be non-zero multiples of 8, timeout_cycles >= 1");
    end

    typedef enum logic [2:0] {IDLE, OPCODE, BLOCK, REG, DATA, INSTR, DELAY, GAP} state_t;
    typedef enum logic [2:0] {K_OPONLY, K_INSTR, K_REG, K_DELAY, K_GAIN, K_BAD} kind_t;

    state_t                  state, state_n, ret_state, ret_n, nxt_field;
    kind_t                   kind_q;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [7:0]              byte_n, ret_byte;
    logic                    done_n, invalid_n, accept, last_byte;
    logic [7:0]              blk_q, reg_q;
    logic [data_width-1:0]   data_q, data_sh;
    logic [instr_width-1:0]  instr_q, instr_sh;
    logic [2*data_width-1:0] delay_q, delay_sh;

`ifdef SERIALIZER_TIMEOUT_EN
    localparam int TMO_W = $clog2(timeout_cycles + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(timeout_cycles - 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             timeout_n, timeout_q;
`endif

    function automatic kind_t decode(input logic [7:0] op);
        case (op)
            CMD_WRITE_BLOCK_INSTR, CMD_WRITE_BLOCK_INSTR | PIPE_SEL:  return K_INSTR;
            CMD_WRITE_BLOCK_REG,   CMD_WRITE_BLOCK_REG | PIPE_SEL,
            CMD_UPDATE_BLOCK_REG,  CMD_UPDATE_BLOCK_REG | PIPE_SEL:   return K_REG;
            CMD_ALLOC_DELAY,       CMD_ALLOC_DELAY | PIPE_SEL:        return K_DELAY;
            CMD_SET_INPUT_GAIN,    CMD_SET_INPUT_GAIN | PIPE_SEL,
            CMD_SET_OUTPUT_GAIN,   CMD_SET_OUTPUT_GAIN | PIPE_SEL:    return K_GAIN;
            CMD_RESET_PIPELINE,    CMD_RESET_PIPELINE | PIPE_SEL,
            CMD_COMMIT_REG_UPDATES, CMD_SWAP_PIPELINES:               return K_OPONLY;
            default:                                                  return K_BAD;
        endcase
    endfunction

    function automatic int field_bytes(input state_t f);
        case (f)
            DATA:    return DATA_BYTES;
            INSTR:   return INSTR_BYTES;
            DELAY:   return DELAY_BYTES;
            default: return 1;
        endcase
    endfunction

    // Field that follows f for a command of kind k; IDLE means f was the last field.
    function automatic state_t next_field(input state_t f, input kind_t k);
        state_t nf;
        nf = IDLE;
        case (f)
            OPCODE: begin
                if (k == K_INSTR || k == K_REG)        nf = BLOCK;
                else if (k == K_DELAY || k == K_GAIN)  nf = DATA;
            end
            BLOCK:  nf = (k == K_INSTR) ? INSTR : REG;
            REG:    nf = DATA;
            DATA:   if (k == K_DELAY) nf = DELAY;
            default: nf = IDLE;
        endcase
        return nf;
    endfunction

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state != IDLE) && (state != GAP);

    // cnt already holds the index of the byte about to be presented when in GAP.
    assign data_sh  = data_q  >> (8 * (DATA_BYTES  - 1 - int'(cnt)));
    assign instr_sh = instr_q >> (8 * (INSTR_BYTES - 1 - int'(cnt)));
    assign delay_sh = delay_q >> (8 * (DELAY_BYTES - 1 - int'(cnt)));

    always_comb begin
        ret_byte = out_byte;
        case (ret_state)
            BLOCK:   ret_byte = blk_q;
            REG:     ret_byte = reg_q;
            DATA:    ret_byte = data_sh[7:0];
            INSTR:   ret_byte = instr_sh[7:0];
            DELAY:   ret_byte = delay_sh[7:0];
            default: ret_byte = out_byte;
        endcase
    end

    always_comb begin
        state_n   = state;
        ret_n     = ret_state;
        cnt_n     = cnt;
        byte_n    = out_byte;
        done_n    = 1'b0;
        invalid_n = 1'b0;
        accept    = 1'b0;
        nxt_field = next_field(state, kind_q);
        last_byte = (int'(cnt) == field_bytes(state) - 1);
`ifdef SERIALIZER_TIMEOUT_EN
        timeout_n = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (decode(cmd_opcode) == K_BAD) begin
                        invalid_n = 1'b1;
                    end else begin
                        state_n = OPCODE;
                        byte_n  = cmd_opcode;
                        cnt_n   = '0;
                    end
                end
            end
            GAP: begin
                state_n = ret_state;
                byte_n  = ret_byte;
            end
            default: begin
                if (out_next) begin
                    state_n = GAP;
                    if (last_byte) begin
                        ret_n  = nxt_field;
                        cnt_n  = '0;
                        done_n = (nxt_field == IDLE);
                    end else begin
                        ret_n  = state;
                        cnt_n  = cnt + 1'b1;
                    end
                end
`ifdef SERIALIZER_TIMEOUT_EN
                else if (tmo_cnt == TMO_LAST) begin
                    state_n   = IDLE;
                    ret_n     = IDLE;
                    cnt_n     = '0;
                    timeout_n = 1'b1;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ret_state <= IDLE;
            cnt       <= '0;
            out_byte  <= '0;
            done      <= 1'b0;
            invalid   <= 1'b0;
        end else begin
            state     <= state_n;
            ret_state <= ret_n;
            cnt       <= cnt_n;
            out_byte  <= byte_n;
            done      <= done_n;
            invalid   <= invalid_n;
        end
    end

    // Command fields are captured once so upstream may change them while the command streams.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kind_q  <= K_OPONLY;
            blk_q   <= '0;
            reg_q   <= '0;
            data_q  <= '0;
            instr_q <= '0;
            delay_q <= '0;
        end else if (accept) begin
            kind_q  <= decode(cmd_opcode);
            blk_q   <= cmd_block;
            reg_q   <= cmd_reg;
            data_q  <= cmd_data;
            instr_q <= cmd_instr;
            delay_q <= cmd_delay;
        end
    end

`ifdef SERIALIZER_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt   <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_n;
            if (out_valid && !out_next) tmo_cnt <= tmo_cnt + 1'b1;
            else                        tmo_cnt <= '0;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: doc/command_serializer.md
COMMAND_SERIALIZER -- requirements
Module: command_serializer

Interface
REQ-001 SHALL have parameter data_width, default 16, gain/register data field width (multiple of 8).
REQ-002 SHALL have parameter instr_width, default 32, block instruction field width (multiple of 8).
REQ-003 SHALL have parameter timeout_cycles, default 1024, cycles to wait for a byte acknowledge before abort (used only under REQ-031).
REQ-004 SHALL have ports in this order:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high only in IDLE; accept when cmd_valid && cmd_ready.
- cmd_opcode  input  8  command byte, COMMAND_* codes from controller.vh.
- cmd_block  input  8  block number.
- cmd_reg  input  8  register number.
- cmd_data  input  data_width  data word.
- cmd_instr  input  instr_width  block instruction.
- cmd_delay  input  2*data_width  buffer initial delay.
- out_byte  output  8  byte to the control unit.
- out_valid  output  1  out_byte is valid.
- out_next  input  1  one-cycle consume pulse from the control unit.
- busy  output  1  not in IDLE.
- done  output  1  one-cycle pulse, command fully sent.
- invalid  output  1  one-cycle pulse, unknown opcode rejected.
- timeout  output  1  one-cycle pulse, abort (REQ-031 only).

Function
REQ-005 SHALL latch all cmd_* fields on acceptance; later input changes SHALL NOT affect the command in flight.
REQ-006 SHALL emit bytes in this order, multi-byte fields MSB first:
- WRITE_BLOCK_INSTR: opcode, block, instr (instr_width/8 bytes).
- WRITE_BLOCK_REG, UPDATE_BLOCK_REG: opcode, block, reg, data (data_width/8 bytes).
- ALLOC_DELAY: opcode, data, delay (2*data_width/8 bytes).
- SET_INPUT_GAIN, SET_OUTPUT_GAIN: opcode, data.
- COMMIT_REG_UPDATES, SWAP_PIPELINES, RESET_PIPELINE: opcode only.
REQ-007 SHALL pass opcode bit 3 (pipeline select) through unmodified; opcode matching SHALL use the full 8 bits.
REQ-008 SHALL, for an opcode outside REQ-006, emit no bytes, pulse invalid the cycle after acceptance and return to IDLE.
REQ-009 SHALL hold out_byte and out_valid stable until out_next is sampled high.
REQ-010 SHALL deassert out_valid for exactly one GAP cycle after each out_next, so no byte is seen twice by a receiver that ignores in_ready on the cycle after consuming.
REQ-011 SHALL present the first byte (opcode) with out_valid on the cycle after acceptance.
REQ-012 SHALL ignore out_next while out_valid is low.
REQ-013 SHALL use states IDLE, OPCODE, BLOCK, REG, DATA, INSTR, DELAY, GAP; GAP returns to the next field state, or to IDLE with a done pulse after the last byte.
REQ-014 SHALL use one byte counter, cleared on each field entry, reaching field_bytes-1 on the last byte of the field.
REQ-015 SHALL, for an opcode-only command, pulse done in the GAP cycle after opcode acknowledge; cmd_ready SHALL return high the next cycle.
REQ-016 SHALL never accept a new command while busy; cmd_valid while busy is ignored, not queued.
REQ-017 SHALL keep out_byte at its last value when out_valid is low; the value is don't-care for receivers.

Reset
REQ-020 SHALL, on reset low, immediately force state IDLE, out_valid 0, out_byte 0, done 0, invalid 0, timeout 0, busy 0, byte counter 0; cmd_ready 1 after release.
REQ-021 SHALL abandon a command interrupted mid-stream by reset with no done pulse; the first command after release SHALL start with its opcode.

Configuration
REQ-030 SHALL use macro SERIALIZER_TIMEOUT_EN.
REQ-031 With SERIALIZER_TIMEOUT_EN defined: a counter SHALL run while out_valid is high and clear on out_next; on reaching timeout_cycles it SHALL drop out_valid, pulse timeout, return to IDLE and give no done.
REQ-032 Without SERIALIZER_TIMEOUT_EN: SHALL wait indefinitely; timeout SHALL be tied 0 and no counter logic generated.

Verification
REQ-040 WRITE_BLOCK_REG, block 0x05, reg 0x03, data 0x1234, out_next 2 cycles after each out_valid -> bytes opcode,05,03,12,34; one low cycle between bytes; done once.
REQ-041 ALLOC_DELAY, data 0x0100, delay 0x00012345 -> opcode,01,00,00,01,23,45; done after 7th ack.
REQ-042 SWAP_PIPELINES -> single opcode byte; done the cycle after ack; cmd_ready high the cycle after done.
REQ-043 opcode 0xFF -> no out_valid; invalid pulse one cycle after acceptance; cmd_ready high again.
REQ-044 reset low after 2nd byte of WRITE_BLOCK_INSTR -> out_valid 0 asynchronously, no done; next command begins with its opcode.
REQ-045 SERIALIZER_TIMEOUT_EN, timeout_cycles 16, out_next never asserted -> timeout pulse 16 cycles after out_valid rises; IDLE; no done.
